// File: rtl/ps2_host_tx_if.sv
// PS/2 host transmitter bundle: CPU-side command handshake plus the
// sampled pin levels and open-drain output-enables.
interface ps2_host_tx_if;
  logic       kclk_in;
  logic       kdata_in;
  logic       kclk_oe;
  logic       kdata_oe;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  // Pin/CPU side: drives the request and the physical line levels.
  modport master (
    output kclk_in, kdata_in, tx_data, tx_start,
    input  kclk_oe, kdata_oe, tx_busy, tx_done, tx_err
  );

  // Transmitter side.
  modport slave (
    input  kclk_in, kdata_in, tx_data, tx_start,
    output kclk_oe, kdata_oe, tx_busy, tx_done, tx_err
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// then shifts one command byte out on device-generated clock falling edges
// and checks the device ack.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | lines released, waiting for tx_start
// INHIBIT   | kclk pulled low to abort any device traffic
// RTS       | kclk and kdata low (start bit), then kclk released
// SEND      | data/parity/stop driven on kclk falls, ack sampled on 11th
// WAIT_IDLE | lines released, waiting for both to read high
// DONE      | one-cycle tx_done, tx_err valid
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RTS_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
  localparam int RTS_W = $clog2(RTS_CYCLES) + 1;
  localparam int PH_W  = (INH_W > RTS_W) ? INH_W : RTS_W;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [PH_W-1:0] INH_LOAD = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] RTS_LOAD = PH_W'(RTS_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, RTS, SEND, WAIT_IDLE, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q;
  logic [TO_W-1:0] to_q;
  logic [3:0]      bit_q;
  logic [9:0]      shift_q;
  logic            dat_oe_q;
  logic            nack_q;
  logic            err_q;

  logic [1:0]      kclk_sync, kdata_sync;
  logic            kclk_prev;
  logic            kclk_s, kdata_s, kclk_fall;
  logic            to_hit, phase_zero;

  assign kclk_s     = kclk_sync[1];
  assign kdata_s    = kdata_sync[1];
  assign kclk_fall  = kclk_prev & ~kclk_s;
  assign to_hit     = (to_q >= TO_LAST);
  assign phase_zero = (phase_q == '0);

  // Two-flop synchronizers; idle lines read high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kclk_sync  <= 2'b11;
      kdata_sync <= 2'b11;
      kclk_prev  <= 1'b1;
    end else begin
      kclk_sync  <= {kclk_sync[0], bus.kclk_in};
      kdata_sync <= {kdata_sync[0], bus.kdata_in};
      kclk_prev  <= kclk_s;
    end
  end

  // State register; async reset releases the lines at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and line/handshake outputs.
  always_comb begin
    state_d      = state_q;
    bus.kclk_oe  = 1'b0;
    bus.kdata_oe = 1'b0;
    bus.tx_done  = 1'b0;
    bus.tx_busy  = (state_q != IDLE);
    bus.tx_err   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.tx_start) state_d = INHIBIT;
      end
      INHIBIT: begin
        bus.kclk_oe = 1'b1;
        if (phase_zero) state_d = RTS;
      end
      RTS: begin
        bus.kclk_oe  = 1'b1;
        bus.kdata_oe = 1'b1;
        if (phase_zero) state_d = SEND;
      end
      SEND: begin
        bus.kdata_oe = dat_oe_q;
        // Timeout takes priority over a coincident final falling edge.
        if (to_hit)                            state_d = DONE;
        else if (kclk_fall && bit_q == 4'd10)  state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (to_hit)                 state_d = DONE;
        else if (kclk_s && kdata_s) state_d = DONE;
      end
      DONE: begin
        bus.tx_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: phase timer, timeout counter, bit shifting and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= '0;
      to_q     <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      dat_oe_q <= 1'b0;
      nack_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.tx_start) begin
            phase_q <= INH_LOAD;
            shift_q <= {~^bus.tx_data, bus.tx_data};
            nack_q  <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        INHIBIT: begin
          if (phase_zero) phase_q <= RTS_LOAD;
          else            phase_q <= phase_q - 1'b1;
        end
        RTS: begin
          if (!phase_zero) phase_q <= phase_q - 1'b1;
          to_q     <= '0;
          bit_q    <= '0;
          dat_oe_q <= 1'b1;
        end
        SEND, WAIT_IDLE: begin
          if (to_q < TO_MAX) to_q <= to_q + 1'b1;
          if (state_q == SEND && kclk_fall) begin
            if (bit_q <= 4'd8)       dat_oe_q <= ~shift_q[bit_q];
            else                     dat_oe_q <= 1'b0;
            if (bit_q == 4'd10)      nack_q   <= kdata_s;
            if (bit_q < 4'd10)       bit_q    <= bit_q + 1'b1;
          end
        end
        default: ;
      endcase
      if (state_q != DONE && state_d == DONE) err_q <= to_hit | nack_q;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and the received bits are compared with a frame built from the byte.
module tb_ps2_host_tx;
  localparam int INH  = 60;
  localparam int RTSC = 12;
  localparam int TO   = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  assign bus.kclk_in  = ~(bus.kclk_oe | dev_clk_low);
  assign bus.kdata_in = ~(bus.kdata_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .RTS_CYCLES(RTSC), .TIMEOUT_CYCLES(TO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int inh_run = 0, inh_last = 0, rts_run = 0, rts_last = 0;
  bit abort_dev = 1'b0;
  int dev_bit = 0;

  // Count done pulses and measure inhibit / request-to-send lengths.
  always @(negedge clk) begin
    if (bus.tx_done) done_cnt <= done_cnt + 1;
    if (bus.kclk_oe && !bus.kdata_oe) inh_run <= inh_run + 1;
    else if (inh_run != 0) begin inh_last <= inh_run; inh_run <= 0; end
    if (bus.kclk_oe && bus.kdata_oe) rts_run <= rts_run + 1;
    else if (rts_run != 0) begin rts_last <= rts_run; rts_run <= 0; end
  end

  // Expected line bits: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2 == 0);
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic dwait(input int n);
    for (int k = 0; k < n; k++) begin
      if (abort_dev) return;
      @(negedge clk);
    end
  endtask

  task automatic start_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  task automatic device_frame(input int h, input bit ack, output logic [10:0] got);
    int t;
    got = '0;
    t = 0;
    while (!(bus.kclk_oe === 1'b0 && bus.kdata_oe === 1'b1) && t < INH + RTSC + 50 && !abort_dev) begin
      @(negedge clk); t++;
    end
    if (t >= INH + RTSC + 50) return;
    dwait(5);
    got[0] = bus.kdata_in;
    for (int i = 1; i <= 10; i++) begin
      dev_bit = i;
      dev_clk_low = 1'b1;
      dwait(h);
      if (abort_dev) return;
      got[i] = bus.kdata_in;
      dev_clk_low = 1'b0;
      dwait(h);
      if (abort_dev) return;
    end
    dev_data_low = ack;
    dev_clk_low  = 1'b1;
    dwait(h);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
  endtask

  task automatic do_frame(input logic [7:0] d, input bit ack, input int h,
                          output logic [10:0] got, output logic done_seen,
                          output logic err_done, output logic err_start,
                          output logic [1:0] oe_done);
    int t;
    start_tx(d);
    err_start = bus.tx_err;
    device_frame(h, ack, got);
    t = 0;
    while (!bus.tx_done && t < 200 && !abort_dev) begin @(negedge clk); t++; end
    done_seen = bus.tx_done;
    err_done  = bus.tx_err;
    oe_done   = {bus.kclk_oe, bus.kdata_oe};
  endtask

  logic [10:0] got;
  logic        dn, ed, es;
  logic [1:0]  oe;

  task automatic test_reset;
    rst = 1'b1;
    bus.tx_data = 8'h00;
    bus.tx_start = 1'b0;
    dwait(3);
    n_checks++; if (bus.kclk_oe !== 1'b0) $display("FAIL reset_kclk_oe: got %b expected 0", bus.kclk_oe); else n_pass++;
    n_checks++; if (bus.kdata_oe !== 1'b0) $display("FAIL reset_kdata_oe: got %b expected 0", bus.kdata_oe); else n_pass++;
    n_checks++; if (bus.tx_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.tx_busy); else n_pass++;
    n_checks++; if (bus.tx_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.tx_done); else n_pass++;
    n_checks++; if (bus.tx_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus.tx_err); else n_pass++;
    rst = 1'b0;
    dwait(3);
  endtask

  task automatic test_ed;
    do_frame(8'hED, 1'b1, 20, got, dn, ed, es, oe);
    n_checks++; if (got !== exp_frame(8'hED)) $display("FAIL ed_frame: got %b expected %b", got, exp_frame(8'hED)); else n_pass++;
    n_checks++; if (dn !== 1'b1) $display("FAIL ed_done: got %b expected 1", dn); else n_pass++;
    n_checks++; if (ed !== 1'b0) $display("FAIL ed_err: got %b expected 0", ed); else n_pass++;
    n_checks++; if (inh_last != INH) $display("FAIL ed_inhibit_len: got %0d expected %0d", inh_last, INH); else n_pass++;
    n_checks++; if (rts_last != RTSC) $display("FAIL ed_rts_len: got %0d expected %0d", rts_last, RTSC); else n_pass++;
  endtask

  task automatic test_f4;
    do_frame(8'hF4, 1'b1, 14, got, dn, ed, es, oe);
    n_checks++; if (got !== exp_frame(8'hF4)) $display("FAIL f4_frame: got %b expected %b", got, exp_frame(8'hF4)); else n_pass++;
    n_checks++; if (dn !== 1'b1) $display("FAIL f4_done: got %b expected 1", dn); else n_pass++;
    n_checks++; if (ed !== 1'b0) $display("FAIL f4_err: got %b expected 0", ed); else n_pass++;
  endtask

  task automatic test_noack;
    do_frame(8'h00, 1'b0, 16, got, dn, ed, es, oe);
    n_checks++; if (got !== exp_frame(8'h00)) $display("FAIL noack_frame: got %b expected %b", got, exp_frame(8'h00)); else n_pass++;
    n_checks++; if (dn !== 1'b1) $display("FAIL noack_done: got %b expected 1", dn); else n_pass++;
    n_checks++; if (ed !== 1'b1) $display("FAIL noack_err: got %b expected 1", ed); else n_pass++;
    n_checks++; if (oe !== 2'b00) $display("FAIL noack_lines: got %b expected 00", oe); else n_pass++;
    dwait(10);
    n_checks++; if (bus.tx_err !== 1'b1) $display("FAIL noack_err_hold: got %b expected 1", bus.tx_err); else n_pass++;
  endtask

  task automatic test_timeout;
    int t, cnt;
    start_tx(8'hA5);
    t = 0;
    while (bus.kclk_oe && t < INH + RTSC + 50) begin @(negedge clk); t++; end
    cnt = 0;
    while (!bus.tx_done && cnt < TO + 100) begin @(negedge clk); cnt++; end
    n_checks++; if (cnt < TO - 3 || cnt > TO + 3) $display("FAIL timeout_cycles: got %0d expected %0d", cnt, TO); else n_pass++;
    n_checks++; if (bus.tx_err !== 1'b1) $display("FAIL timeout_err: got %b expected 1", bus.tx_err); else n_pass++;
    n_checks++; if (bus.kclk_oe !== 1'b0) $display("FAIL timeout_kclk_oe: got %b expected 0", bus.kclk_oe); else n_pass++;
    n_checks++; if (bus.kdata_oe !== 1'b0) $display("FAIL timeout_kdata_oe: got %b expected 0", bus.kdata_oe); else n_pass++;
    dwait(5);
  endtask

  task automatic test_random;
    logic [7:0] d;
    bit a;
    int h;
    for (int r = 0; r < 4; r++) begin
      d = 8'($urandom);
      a = 1'($urandom_range(0, 1));
      h = int'($urandom_range(10, 20));
      do_frame(d, a, h, got, dn, ed, es, oe);
      n_checks++; if (got !== exp_frame(d)) $display("FAIL rand_frame: byte %h got %b expected %b", d, got, exp_frame(d)); else n_pass++;
      n_checks++; if (ed !== !a) $display("FAIL rand_err: byte %h got %b expected %b", d, ed, !a); else n_pass++;
      n_checks++; if (es !== 1'b0) $display("FAIL rand_err_clear: got %b expected 0", es); else n_pass++;
      dwait(5);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = done_cnt;
    fork
      do_frame(8'hED, 1'b1, 12, got, dn, ed, es, oe);
      begin
        dwait(INH + RTSC + 60);
        bus.tx_data  = 8'h55;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
      end
    join
    dwait(100);
    n_checks++; if (got !== exp_frame(8'hED)) $display("FAIL b2b_frame: got %b expected %b", got, exp_frame(8'hED)); else n_pass++;
    n_checks++; if (done_cnt - base != 1) $display("FAIL b2b_done_count: got %0d expected 1", done_cnt - base); else n_pass++;
    n_checks++; if (bus.tx_busy !== 1'b0) $display("FAIL b2b_busy_after: got %b expected 0", bus.tx_busy); else n_pass++;
    n_checks++; if (bus.kclk_oe !== 1'b0) $display("FAIL b2b_kclk_after: got %b expected 0", bus.kclk_oe); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int t;
    dev_bit = 0;
    fork
      do_frame(8'h26, 1'b1, 15, got, dn, ed, es, oe);
      begin
        t = 0;
        while (dev_bit != 4 && t < 2000) begin @(negedge clk); t++; end
        dwait(4);
        n_checks++; if (bus.kdata_oe !== 1'b1) $display("FAIL rstmid_pre_kdata: got %b expected 1", bus.kdata_oe); else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_checks++; if (bus.kclk_oe !== 1'b0) $display("FAIL rstmid_kclk_oe: got %b expected 0", bus.kclk_oe); else n_pass++;
        n_checks++; if (bus.kdata_oe !== 1'b0) $display("FAIL rstmid_kdata_oe: got %b expected 0", bus.kdata_oe); else n_pass++;
        n_checks++; if (bus.tx_busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.tx_busy); else n_pass++;
        abort_dev = 1'b1;
      end
    join
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    abort_dev    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dwait(3);
    do_frame(8'hFF, 1'b1, 13, got, dn, ed, es, oe);
    n_checks++; if (got !== exp_frame(8'hFF)) $display("FAIL rstmid_ff_frame: got %b expected %b", got, exp_frame(8'hFF)); else n_pass++;
    n_checks++; if (got[9] !== 1'b1) $display("FAIL rstmid_ff_parity: got %b expected 1", got[9]); else n_pass++;
    n_checks++; if (ed !== 1'b0 || dn !== 1'b1) $display("FAIL rstmid_ff_done: got done %b err %b expected done 1 err 0", dn, ed); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ed();
    test_f4();
    test_noack();
    test_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end
endmodule
